// File: rtl/axis_pkt_fifo.sv
`default_nettype none
// ==========================================================================
// axis_pkt_fifo : AXI-Stream FIFO, registered ready/valid, packet counter,
// 1-cycle back-channel; store-and-forward via AXIS_PKT_FIFO_STORE_FWD_EN. r1.0
// ==========================================================================
module axis_pkt_fifo #(
    parameter int DWIDTH = 76,
    parameter int UWIDTH = 1,
    parameter int DEPTH  = 16,
    parameter int LWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DWIDTH-1:0] s_tdata,
    input  logic [UWIDTH-1:0] s_tuser,
    input  logic              s_tlast,
    output logic              s_tuser_slv,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DWIDTH-1:0] m_tdata,
    output logic [UWIDTH-1:0] m_tuser,
    output logic              m_tlast,
    input  logic              m_tuser_slv,
    output logic [LWIDTH-1:0] level,
    output logic [LWIDTH-1:0] pkt_cnt
);

    localparam int                c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_EW      = DWIDTH + UWIDTH + 1;
    localparam logic [LWIDTH-1:0] c_DEPTH_L = LWIDTH'(DEPTH);
    localparam logic [LWIDTH-1:0] c_ONE_L   = LWIDTH'(1);

    logic [c_EW-1:0]   mem_q [DEPTH];
    logic [c_AW-1:0]   wr_ptr_q;
    logic [c_AW-1:0]   rd_ptr_q;
    logic [LWIDTH-1:0] level_q;
    logic [LWIDTH-1:0] level_d;
    logic [LWIDTH-1:0] pkt_cnt_q;
    logic [LWIDTH-1:0] pkt_cnt_d;
    logic              s_tready_q;
    logic              s_tready_d;
    logic              m_tvalid_q;
    logic              m_tvalid_d;
    logic              tuser_slv_q;

    logic [c_EW-1:0]   w_head;
    logic              w_head_last;
    logic              w_push;
    logic              w_pop;
    logic              w_push_last;
    logic              w_pop_last;

    assign w_head      = mem_q[rd_ptr_q];
    assign w_head_last = w_head[0];
    assign w_push      = s_tvalid && s_tready_q;
    assign w_pop       = m_tvalid_q && m_tready;
    assign w_push_last = w_push && s_tlast;
    assign w_pop_last  = w_pop && w_head_last;

    always_comb begin
        level_d   = level_q;
        pkt_cnt_d = pkt_cnt_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + c_ONE_L;
            2'b01:   level_d = level_q - c_ONE_L;
            default: level_d = level_q;
        endcase
        case ({w_push_last, w_pop_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + c_ONE_L;
            2'b01:   pkt_cnt_d = pkt_cnt_q - c_ONE_L;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
        // Ready looks at next-cycle occupancy so m_tready never reaches s_tready combinationally.
        s_tready_d = (level_d < c_DEPTH_L);
    end

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    logic in_pkt_q;
    logic in_pkt_d;
    logic esc_q;
    logic esc_d;

    always_comb begin
        in_pkt_d = in_pkt_q;
        esc_d    = esc_q;
        if (w_pop) begin
            in_pkt_d = !w_head_last;
        end
        if (w_pop_last) begin
            esc_d = 1'b0;
        end
        // A full FIFO holding no complete packet could never release; fall back to cut-through.
        if ((level_d == c_DEPTH_L) && (pkt_cnt_d == '0)) begin
            esc_d = 1'b1;
        end
        m_tvalid_d = (level_d != '0) && ((pkt_cnt_d != '0) || in_pkt_d || esc_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_pkt_q <= 1'b0;
            esc_q    <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
            esc_q    <= esc_d;
        end
    end
`else
    always_comb begin
        m_tvalid_d = (level_d != '0);
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pkt_cnt_q   <= '0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            tuser_slv_q <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q     <= level_d;
            pkt_cnt_q   <= pkt_cnt_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            tuser_slv_q <= m_tuser_slv;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {s_tdata, s_tuser, s_tlast};
        end
    end

    assign s_tready    = s_tready_q;
    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = w_head[c_EW-1 -: DWIDTH];
    assign m_tuser     = w_head[UWIDTH:1];
    assign m_tlast     = w_head_last;
    assign s_tuser_slv = tuser_slv_q;
    assign level       = level_q;
    assign pkt_cnt     = pkt_cnt_q;

endmodule
`default_nettype wire

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Parametrised AXI-Stream FIFO buffer for the l3l4cs datapath, placed between an AXI-Stream master and slave stage.
- Generalises the fixed 76-bit stream channel: configurable data and user widths, configurable depth, and registered decoupling in both directions.
- Carries the 1-bit slave back-channel (tuser_slv) upstream with a fixed 1-cycle delay.
- Reports occupancy and the count of complete packets stored.

Parameters:
- DWIDTH, 76, tdata width in bits.
- UWIDTH, 1, tuser width in bits.
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- LWIDTH, $clog2(DEPTH+1), width of the level and pkt_cnt outputs (derived; do not override).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_tvalid  in  1  upstream beat valid.
- s_tready  out  1  FIFO can accept a beat.
- s_tdata  in  DWIDTH  upstream data.
- s_tuser  in  UWIDTH  upstream sideband.
- s_tlast  in  1  end of packet.
- s_tuser_slv  out  1  back-channel to upstream; equals m_tuser_slv delayed by 1 cycle.
- m_tvalid  out  1  head beat valid.
- m_tready  in  1  downstream accepts.
- m_tdata  out  DWIDTH  head data.
- m_tuser  out  UWIDTH  head sideband.
- m_tlast  out  1  head end-of-packet.
- m_tuser_slv  in  1  back-channel from downstream.
- level  out  LWIDTH  entries currently stored (0..DEPTH).
- pkt_cnt  out  LWIDTH  stored beats with tlast=1.

Behaviour:
- Reset (async assert, sync release): read/write pointers=0, level=0, pkt_cnt=0, s_tready=0, m_tvalid=0, s_tuser_slv=0. Storage contents are don't-care.
- The first rising edge after reset release sets s_tready=1.
- Push: occurs on s_tvalid && s_tready; stores {tdata,tuser,tlast} at wr_ptr, then wr_ptr++ (wraps DEPTH-1 -> 0).
- Pop: occurs on m_tvalid && m_tready; rd_ptr++ (wraps).
- s_tready is registered: it is 1 exactly when the next-cycle level < DEPTH. There is no combinational path m_tready -> s_tready.
- m_tvalid is registered: it rises the cycle after the first push into an empty FIFO. Push-to-output latency is 1 cycle.
- m_tdata, m_tuser and m_tlast always reflect the entry at rd_ptr while m_tvalid=1. They must not change while m_tvalid && !m_tready.
- Simultaneous push and pop:
  - level unchanged.
  - When full, no push is possible because s_tready=0; a pop when full raises s_tready on the next cycle.
  - When empty, a push is never concurrent with a pop because m_tvalid=0; the pushed beat appears on the next cycle.
- pkt_cnt: +1 on a push with tlast=1, -1 on a pop with tlast=1, net 0 when both occur in the same cycle.
- level: +1 on push, -1 on pop.
- Neither level nor pkt_cnt may ever exceed DEPTH or underflow below 0.
- Full boundary: level==DEPTH means s_tready=0 and no write occurs, whatever s_tvalid is.
- Empty boundary: level==0 means m_tvalid=0 and no pointer movement, whatever m_tready is.
- s_tuser_slv is a flop of m_tuser_slv, independent of FIFO state.
- Reset asserted mid-packet: all in-flight beats are discarded immediately. No partial packet survives reset.
- Upstream stalls: s_tvalid may drop mid-packet. The FIFO does not require contiguous beats.

Optional Feature:
- Macro: AXIS_PKT_FIFO_STORE_FWD_EN.
- Defined (store-and-forward):
  - m_tvalid=1 only when pkt_cnt>0, or when the head beat belongs to a packet already partially popped (release in progress).
  - Once the first beat of a packet is presented, the rest of that packet streams without waiting.
  - Deadlock escape: if level==DEPTH and pkt_cnt==0, the FIFO switches to cut-through until the next popped tlast.
- Undefined: cut-through exactly as in Behaviour; pkt_cnt is still maintained.

Test Plan:
- Reset then idle, DEPTH=16:
  - Before the first clock edge after release: s_tready=0, m_tvalid=0, level=0, pkt_cnt=0.
  - After that edge: s_tready=1.
- Fill to full with m_tready=0:
  - Push 16 beats with tdata=0..15.
  - Required: level=16, s_tready=0 on the cycle after the 16th push, and a 17th beat held by upstream is not written.
  - Then drain with m_tready=1: order 0..15, level back to 0, m_tvalid=0.
- Continuous streaming:
  - s_tvalid=1 and m_tready=1 for 100 beats.
  - Required: one beat per cycle after the 1-cycle latency, level steady at 1, no bubbles.
- Packet count:
  - Push packets of 3, 1 and 5 beats (tlast on the last beat of each).
  - Required: pkt_cnt=3. Popping the 4th beat brings pkt_cnt to 1.
  - Simultaneous push-tlast and pop-tlast leaves pkt_cnt unchanged.
- Back-channel and reset:
  - Toggle m_tuser_slv.
  - Required: s_tuser_slv follows exactly 1 cycle later.
  - Assert reset_n=0 mid-packet with level=7: level=0 and m_tvalid=0 immediately, without waiting for a clock.
- STORE_FWD_EN:
  - Push 4 beats without tlast: m_tvalid stays 0.
  - Push a 5th beat with tlast: m_tvalid=1 the next cycle.
  - Push 16 beats without tlast into a 16-deep FIFO: cut-through escape fires and m_tvalid=1.
